hex_load_ctrl: RTL

- Boot-load controller that sequences the Intel-HEX parser.
- Buffers raw UART bytes and paces them into the parser so that no byte lands in a parser non-consuming cycle.
- Commits parsed bytes to program memory through a write-port mux shared with the CPU, and holds the CPU in reset while a load is running.
- Latches completion and error status for the host and debug LEDs.

---
 rtl/hex_pkg.sv | 34 +++
 rtl/byte_fifo.sv | 75 +++++++
 rtl/hex_load_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared types and constants for the hex boot-load controller
package hex_pkg;

  // Error codes shared with the Intel-HEX parser.
  typedef enum logic [2:0] {
    ERR_OK                    = 3'd0,
    ERR_DATA_INVALID          = 3'd1,
    ERR_DATA_OUT_OF_ORDER     = 3'd2,
    ERR_DATA_TYPE_UNSUPPORTED = 3'd3,
    ERR_CRC_MISMATCH          = 3'd4,
    ERR_TIMEOUT               = 3'd5,
    ERR_RX_OVERFLOW           = 3'd6
  } hex_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } load_state_e;

  // Byte that drops the parser back to idle from any mid-line state.
  localparam logic [7:0] FLUSH_BYTE = 8'h00;

  // FLUSH lasts three cycles: index of the final one.
  localparam logic [1:0] FLUSH_LAST = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with registered flags and same-cycle push/pop
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/hex_load_ctrl.sv
// rtl/hex_load_ctrl.sv - boot-load sequencer between UART, hex parser and program memory
module hex_load_ctrl
  import hex_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter int          ADDR_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_hex_en,
  output logic [7:0]        o_hex_data,
  input  logic [15:0]       i_hex_addr,
  input  logic [7:0]        i_hex_data,
  input  logic              i_hex_valid,
  input  logic [2:0]        i_hex_error,
  input  logic              i_hex_complete,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_error_code,
  output logic [15:0]       o_bytes_written
);

  load_state_e       state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic              hex_en_q, hex_en_d;
  logic [7:0]        hex_data_q, hex_data_d;
  logic              wbuf_full_q, wbuf_full_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [7:0]        wbuf_data_q, wbuf_data_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic [15:0]       bytes_q, bytes_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              mem_fire;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (i_rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state, parser pacing, write buffer and status bookkeeping.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hex_en_d    = 1'b0;
    hex_data_d  = hex_data_q;
    wbuf_full_d = wbuf_full_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    done_d      = done_q;
    err_d       = err_q;
    bytes_d     = bytes_q;
    tmo_d       = tmo_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;

    mem_fire = (state_q == ST_LOAD || state_q == ST_DRAIN) && wbuf_full_q && i_mem_ready;
    if (mem_fire) begin
      wbuf_full_d = 1'b0;
      bytes_d     = sat_inc16(bytes_q);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 2'd0;
          hex_en_d    = 1'b1;
          hex_data_d  = FLUSH_BYTE;
          done_d      = 1'b0;
          err_d       = ERR_OK;
          bytes_d     = 16'd0;
          wbuf_full_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        // Parser errors raised while it digests the flush byte are not captured here.
        fifo_clear = 1'b1;
        tmo_d      = 24'd0;
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_LOAD;
        else                           flush_cnt_d = flush_cnt_q + 2'd1;
      end
      ST_LOAD: begin
        // Feed only when the parser is known to be consuming: never back-to-back,
        // never while a parsed byte is arriving or waiting to be written.
        fifo_push = i_rx_valid;
        fifo_pop  = !fifo_empty && !hex_en_q && !wbuf_full_q && !i_hex_valid;
        if (fifo_pop) begin
          hex_en_d   = 1'b1;
          hex_data_d = fifo_dout;
        end
        if (i_hex_valid) begin
          wbuf_full_d = 1'b1;
          wbuf_addr_d = ADDR_W'(i_hex_addr);
          wbuf_data_d = i_hex_data;
        end
        tmo_d = i_rx_valid ? 24'd0 : tmo_q + 24'd1;
        if (i_hex_error != ERR_OK) begin
          state_d = ST_ERROR;
          err_d   = i_hex_error;
        end else if (i_rx_valid && fifo_full && !fifo_pop) begin
          state_d = ST_ERROR;
          err_d   = ERR_RX_OVERFLOW;
        end else if (!i_rx_valid && tmo_q == TIMEOUT_CYCLES - 24'd1) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (i_hex_complete) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!wbuf_full_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_FLUSH) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    cpu_rst_n_d = !(busy_d || state_d == ST_ERROR);
  end

  // Memory port: CPU passthrough when it runs, write buffer while loading, blocked otherwise.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = wbuf_addr_q;
    o_mem_wdata = wbuf_data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        o_mem_we    = i_cpu_we;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
      end
      ST_LOAD, ST_DRAIN: o_mem_we = wbuf_full_q;
      default:           o_mem_we = 1'b0;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 2'd0;
      hex_en_q    <= 1'b0;
      hex_data_q  <= 8'h00;
      wbuf_full_q <= 1'b0;
      wbuf_addr_q <= '0;
      wbuf_data_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 3'd0;
      bytes_q     <= 16'd0;
      tmo_q       <= 24'd0;
      busy_q      <= 1'b0;
      cpu_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hex_en_q    <= hex_en_d;
      hex_data_q  <= hex_data_d;
      wbuf_full_q <= wbuf_full_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_data_q <= wbuf_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bytes_q     <= bytes_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign o_hex_en        = hex_en_q;
  assign o_hex_data      = hex_data_q;
  assign o_cpu_rst_n     = cpu_rst_n_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error_code    = err_q;
  assign o_bytes_written = bytes_q;

endmodule
